// File: rtl/carry_select_adder_64.sv
// Carry-select adder: duplicated ripple blocks with per-block select mux.
// One output register stage; {c_out,out} = a + b + c_in one cycle later.
`timescale 1ns/1ps

module csa_full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);

endmodule

module csa_ripple_block #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        csa_full_adder u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[W];

endmodule

module csa_mux2 #(
    parameter int W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

module carry_select_adder_64 #(
    parameter int WIDTH   = 64,
    parameter int BLOCK_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] out,
    output logic             c_out
);

    localparam int NBLK = WIDTH / BLOCK_W;

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             c_out_d;
    logic             c_out_q;
    logic [NBLK:0]    blk_c;

    assign blk_c[0] = c_in;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        localparam int LO = k * BLOCK_W;

        if (k == 0) begin : g_first
            csa_ripple_block #(.W(BLOCK_W)) u_rca (
                .x  (a[LO +: BLOCK_W]),
                .y  (b[LO +: BLOCK_W]),
                .ci (blk_c[0]),
                .s  (out_d[LO +: BLOCK_W]),
                .co (blk_c[1])
            );
        end else begin : g_sel
            logic [BLOCK_W-1:0] s0;
            logic [BLOCK_W-1:0] s1;
            logic               c0;
            logic               c1;

            csa_ripple_block #(.W(BLOCK_W)) u_rca0 (
                .x  (a[LO +: BLOCK_W]),
                .y  (b[LO +: BLOCK_W]),
                .ci (1'b0),
                .s  (s0),
                .co (c0)
            );

            csa_ripple_block #(.W(BLOCK_W)) u_rca1 (
                .x  (a[LO +: BLOCK_W]),
                .y  (b[LO +: BLOCK_W]),
                .ci (1'b1),
                .s  (s1),
                .co (c1)
            );

            // The previous block's selected carry picks both sum and carry.
            csa_mux2 #(.W(BLOCK_W)) u_smux (
                .sel (blk_c[k]),
                .d0  (s0),
                .d1  (s1),
                .y   (out_d[LO +: BLOCK_W])
            );

            csa_mux2 #(.W(1)) u_cmux (
                .sel (blk_c[k]),
                .d0  (c0),
                .d1  (c1),
                .y   (blk_c[k+1])
            );
        end
    end

    assign c_out_d = blk_c[NBLK];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            c_out_q <= c_out_d;
        end
    end

    assign out   = out_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_carry_select_adder_64.sv
// Bench for carry_select_adder_64: directed corners plus random vectors,
// run on BLOCK_W = 4, 8 and 16 instances against an arithmetic model.
`timescale 1ns/1ps

module tb_carry_select_adder_64;

    logic        clk;
    logic        rst_n;
    logic [63:0] a;
    logic [63:0] b;
    logic        c_in;
    logic [63:0] out4, out8, out16;
    logic        c4, c8, c16;

    int errors = 0;
    int checks = 0;

    carry_select_adder_64 #(.WIDTH(64), .BLOCK_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in),
        .out(out4), .c_out(c4)
    );

    carry_select_adder_64 #(.WIDTH(64), .BLOCK_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in),
        .out(out8), .c_out(c8)
    );

    carry_select_adder_64 #(.WIDTH(64), .BLOCK_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in),
        .out(out16), .c_out(c16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [64:0] ref_sum(input logic [63:0] x,
                                            input logic [63:0] y,
                                            input logic        c);
        return {1'b0, x} + {1'b0, y} + {64'd0, c};
    endfunction

    task automatic check_all(input string tag, input logic [64:0] exp,
                             input logic [63:0] oa, input logic [63:0] ob,
                             input logic oc);
        checks++;
        assert ({c4, out4} === exp) else begin
            errors++;
            $error("FAIL %s bw4 a=%h b=%h cin=%b got=%h exp=%h",
                   tag, oa, ob, oc, {c4, out4}, exp);
        end
        checks++;
        assert ({c8, out8} === exp) else begin
            errors++;
            $error("FAIL %s bw8 a=%h b=%h cin=%b got=%h exp=%h",
                   tag, oa, ob, oc, {c8, out8}, exp);
        end
        checks++;
        assert ({c16, out16} === exp) else begin
            errors++;
            $error("FAIL %s bw16 a=%h b=%h cin=%b got=%h exp=%h",
                   tag, oa, ob, oc, {c16, out16}, exp);
        end
    endtask

    task automatic step(input string tag, input logic [63:0] va,
                        input logic [63:0] vb, input logic vc);
        logic [64:0] exp;
        @(negedge clk);
        a    = va;
        b    = vb;
        c_in = vc;
        exp  = ref_sum(va, vb, vc);
        @(posedge clk);
        #1;
        check_all(tag, exp, va, vb, vc);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        logic [64:0] held;

        rst_n = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;

        #2;
        check_all("reset_async", 65'd0, a, b, c_in);
        a = 64'hFFFF_FFFF_FFFF_FFFF;
        b = 64'h1;
        @(posedge clk);
        #1;
        check_all("reset_hold", 65'd0, a, b, c_in);
        @(negedge clk);
        rst_n = 1'b1;

        step("one_plus_one", 64'h1, 64'h1, 1'b0);
        step("ones_plus_one", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        step("ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        step("compl_c0", 64'h0123_4567_89AB_CDEF,
             64'hFEDC_BA98_7654_3210, 1'b0);
        step("compl_c1", 64'h1234_5678_9ABC_DEF0,
             64'hEDCB_A987_6543_210F, 1'b1);
        step("b2b_first", 64'h1, 64'h2, 1'b0);
        step("b2b_second", 64'h3, 64'h4, 1'b1);
        step("max_max_c1", 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        step("zero", 64'h0, 64'h0, 1'b0);

        // Only the value present at the edge counts.
        @(negedge clk);
        a    = 64'h5;
        b    = 64'h5;
        c_in = 1'b1;
        #2;
        a    = 64'h7;
        b    = 64'h8;
        c_in = 1'b0;
        @(posedge clk);
        #1;
        check_all("late_change", 65'd15, a, b, c_in);
        held = 65'd15;
        a    = 64'hDEAD_BEEF_0000_0001;
        b    = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        check_all("hold_between", held, a, b, c_in);

        step("pre_reset", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("reset_mid", 65'd0, a, b, c_in);
        @(posedge clk);
        #1;
        check_all("reset_mid_hold", 65'd0, a, b, c_in);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset_release", {1'b1, 64'h0}, a, b, c_in);

        for (int i = 0; i < 10000; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom);
            if ((i % 4) == 1) rb = ~ra;
            if ((i % 16) == 3) ra = 64'hFFFF_FFFF_FFFF_FFFF;
            step("random", ra, rb, rc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
